wb_trace_buffer: RTL and testbench

- Synthesizable writeback-commit trace buffer that sits directly downstream of the data path's WB stage.
- It consumes each register-file write (pc, rd, w_data) and records it in a circular buffer.
- It stops on a programmable data-value trigger plus a post-trigger window, then exposes the captured history through an indexed read port.
- It replaces ad-hoc pass checks on the WB write data, such as the factorial result 720, with a hardware-observable capture.

---
 rtl/wb_trace_pkg.sv | 18 +
 rtl/wb_trace_ram.sv | 23 ++
 rtl/wb_trace_buffer.sv | 98 +++++++++
 tb/tb_wb_trace_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback-commit trace buffer.
package wb_trace_pkg;
  localparam int WORD_W = 64;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [4:0]        rd;
    logic [WORD_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wb_trace_ram.sv
// Trace storage: one synchronous write port, one registered read port, storage not reset.
module wb_trace_ram
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);
  entry_t mem [DEPTH];

  // Nonblocking read and write in one block: a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/wb_trace_buffer.sv
// Circular capture of WB register-file commits with a value trigger and post-trigger window.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int WORD      = WORD_W,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [WORD-1:0] wb_data,
  input  logic [WORD-1:0] wb_pc,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [WORD-1:0] trig_value,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_idx,
  output logic            rd_valid,
  output logic [4:0]      rd_rd,
  output logic [WORD-1:0] rd_data,
  output logic [WORD-1:0] rd_pc,
  output logic [1:0]      state,
  output logic [AW:0]     fill,
  output logic [AW-1:0]   trig_idx,
  output logic [31:0]     commit_cnt
);
  trace_state_t  st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] post_cnt;
  logic [AW:0]   trig_tmp;
  logic [AW-1:0] raddr;
  logic          qual, hit, cap;
  entry_t        wentry, rentry;

  assign qual = wb_valid && (wb_rd != XZR);
  assign hit  = qual && trig_en && (wb_data == trig_value);
  assign cap  = !arm && qual && ((st == ARMED) || (st == POST));

  assign wentry = '{pc: wb_pc, rd: wb_rd, data: wb_data};
  assign raddr  = wr_ptr - fill[AW-1:0] + rd_idx;

  assign trig_tmp = fill - (AW+1)'(POST_TRIG + 1);
  assign trig_idx = trig_tmp[AW-1:0];
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      commit_cnt <= '0;
    end else if (arm) begin
      st         <= ARMED;
      wr_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      commit_cnt <= '0;
    end else if (cap) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != (AW+1)'(DEPTH)) fill <= fill + 1'b1;
      if (commit_cnt != '1) commit_cnt <= commit_cnt + 1'b1;
      if (st == ARMED && hit) begin
        if (POST_TRIG == 0) st <= DONE;
        else begin
          post_cnt <= AW'(POST_TRIG);
          st       <= POST;
        end
      end else if (st == POST) begin
        post_cnt <= post_cnt - 1'b1;
        if (post_cnt == AW'(1)) st <= DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_req && ({1'b0, rd_idx} < fill);
  end

  wb_trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (cap),
    .waddr (wr_ptr),
    .wdata (wentry),
    .re    (rd_req),
    .raddr (raddr),
    .rdata (rentry)
  );

  // Data outputs read as zero unless the response is valid.
  assign rd_rd   = rd_valid ? rentry.rd   : '0;
  assign rd_data = rd_valid ? rentry.data : '0;
  assign rd_pc   = rd_valid ? rentry.pc   : '0;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench: two trace buffers (POST_TRIG=2 and 8) on a shared commit bus.
module tb_wb_trace_buffer;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [63:0] wb_data = '0, wb_pc = '0, trig_value = '0;
  logic        trig_en = 1'b0;
  logic        arm0 = 1'b0, arm1 = 1'b0, rd_req0 = 1'b0, rd_req1 = 1'b0;
  logic [AW-1:0] rd_idx = '0;

  logic        rd_valid0, rd_valid1;
  logic [4:0]  rd_rd0, rd_rd1;
  logic [63:0] rd_data0, rd_data1, rd_pc0, rd_pc1;
  logic [1:0]  state0, state1;
  logic [AW:0] fill0, fill1;
  logic [AW-1:0] trig_idx0, trig_idx1;
  logic [31:0] cc0, cc1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] pc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic seen0, seen1;

  always #5 clk = ~clk;

  wb_trace_buffer #(.WORD(64), .DEPTH(16), .POST_TRIG(2)) u0 (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .arm(arm0), .trig_en(trig_en), .trig_value(trig_value),
    .rd_req(rd_req0), .rd_idx(rd_idx), .rd_valid(rd_valid0), .rd_rd(rd_rd0),
    .rd_data(rd_data0), .rd_pc(rd_pc0), .state(state0), .fill(fill0),
    .trig_idx(trig_idx0), .commit_cnt(cc0));

  wb_trace_buffer #(.WORD(64), .DEPTH(16), .POST_TRIG(8)) u1 (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .arm(arm1), .trig_en(trig_en), .trig_value(trig_value),
    .rd_req(rd_req1), .rd_idx(rd_idx), .rd_valid(rd_valid1), .rd_rd(rd_rd1),
    .rd_data(rd_data1), .rd_pc(rd_pc1), .state(state1), .fill(fill1),
    .trig_idx(trig_idx1), .commit_cnt(cc1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_rd(input string name, input exp_t e, input logic v, input logic [4:0] rd,
                        input logic [63:0] data, input logic [63:0] pc);
    checks++;
    if (v !== e.v || rd !== e.rd || data !== e.data || pc !== e.pc) begin
      failures++;
      $display("FAIL %s: got v=%0b rd=%0d data=%0d pc=%0h expected v=%0b rd=%0d data=%0d pc=%0h",
               name, v, rd, data, pc, e.v, e.rd, e.data, e.pc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin seen0 <= 1'b0; seen1 <= 1'b0; end
    else begin seen0 <= rd_req0; seen1 <= rd_req1; end
  end

  // Monitor: a request captured at the last edge must have a response now.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seen0) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd0_unexpected: got response with empty scoreboard");
        end else cmp_rd("rd0", q0.pop_front(), rd_valid0, rd_rd0, rd_data0, rd_pc0);
      end else chk("rd0_idle_valid", {63'd0, rd_valid0}, 64'd0);
      if (seen1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd1_unexpected: got response with empty scoreboard");
        end else cmp_rd("rd1", q1.pop_front(), rd_valid1, rd_rd1, rd_data1, rd_pc1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d; wb_pc = pc;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic pulse_arm(input bit which);
    if (which) arm1 = 1'b1; else arm0 = 1'b1;
    tick();
    arm0 = 1'b0; arm1 = 1'b0;
  endtask

  task automatic read(input bit which, input logic [AW-1:0] idx, input logic v,
                      input logic [4:0] rd, input logic [63:0] d, input logic [63:0] pc);
    exp_t e;
    e.v = v; e.rd = rd; e.data = d; e.pc = pc;
    rd_idx = idx;
    if (which) begin q1.push_back(e); rd_req1 = 1'b1; end
    else begin q0.push_back(e); rd_req0 = 1'b1; end
    tick();
    rd_req0 = 1'b0; rd_req1 = 1'b0;
  endtask

  logic [63:0] fact [9] = '{64'd1, 64'd2, 64'd6, 64'd24, 64'd120, 64'd720, 64'd7, 64'd8, 64'd9};

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {62'd0, state0}, 64'd0);
    chk("rst_fill", {59'd0, fill0}, 64'd0);
    chk("rst_cc", {32'd0, cc0}, 64'd0);
    rst_n = 1'b1;
    tick();
    read(0, 4'd0, 1'b0, 5'd0, 64'd0, 64'd0);

    // Factorial trigger on u0 (POST_TRIG=2)
    trig_en = 1'b1; trig_value = 64'd720;
    pulse_arm(0);
    chk("arm_state", {62'd0, state0}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      commit(5'd9, fact[i], 64'h100 + 64'(4 * i));
      if (i == 5) chk("fact_post", {62'd0, state0}, 64'd2);
    end
    chk("fact_done", {62'd0, state0}, 64'd3);
    commit(5'd9, fact[8], 64'h120);
    chk("fact_fill", {59'd0, fill0}, 64'd8);
    chk("fact_cc", {32'd0, cc0}, 64'd8);
    chk("fact_trig_idx", {60'd0, trig_idx0}, 64'd5);
    chk("u1_idle_fill", {59'd0, fill1}, 64'd0);
    for (int i = 0; i < 8; i++)
      read(0, 4'(i), 1'b1, 5'd9, fact[i], 64'h100 + 64'(4 * i));
    read(0, 4'd8, 1'b0, 5'd0, 64'd0, 64'd0);

    // Wrap on u1 (POST_TRIG=8), trigger 20; first commit overlaps an empty read
    trig_value = 64'd20;
    pulse_arm(1);
    for (int k = 1; k <= 30; k++) begin
      if (k == 1) begin
        exp_t e;
        e.v = 1'b0; e.rd = '0; e.data = '0; e.pc = '0;
        q1.push_back(e);
        rd_idx = 4'd0; rd_req1 = 1'b1;
      end
      commit(5'(1 + (k % 30)), 64'(k), 64'(4 * k));
      rd_req1 = 1'b0;
      if (k == 28) chk("wrap_done", {62'd0, state1}, 64'd3);
    end
    chk("wrap_fill", {59'd0, fill1}, 64'd16);
    chk("wrap_trig_idx", {60'd0, trig_idx1}, 64'd7);
    chk("wrap_cc", {32'd0, cc1}, 64'd28);
    read(1, 4'd0, 1'b1, 5'd14, 64'd13, 64'd52);
    read(1, 4'd7, 1'b1, 5'd21, 64'd20, 64'd80);
    read(1, 4'd15, 1'b1, 5'd29, 64'd28, 64'd112);

    // XZR ignored, then same commit to x5 fires
    trig_value = 64'd720;
    pulse_arm(0);
    commit(5'd31, 64'd720, 64'h200);
    chk("xzr_state", {62'd0, state0}, 64'd1);
    chk("xzr_fill", {59'd0, fill0}, 64'd0);
    chk("xzr_cc", {32'd0, cc0}, 64'd0);
    commit(5'd5, 64'd720, 64'h204);
    chk("x5_state", {62'd0, state0}, 64'd2);
    chk("x5_fill", {59'd0, fill0}, 64'd1);

    // Re-arm in POST with a coincident commit
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'd3; wb_pc = 64'h208; arm0 = 1'b1;
    tick();
    wb_valid = 1'b0; arm0 = 1'b0;
    chk("rearm_state", {62'd0, state0}, 64'd1);
    chk("rearm_fill", {59'd0, fill0}, 64'd0);
    chk("rearm_cc", {32'd0, cc0}, 64'd0);
    read(0, 4'd0, 1'b0, 5'd0, 64'd0, 64'd0);

    // Asynchronous reset in POST
    commit(5'd5, 64'd720, 64'h20c);
    chk("pre_rst_state", {62'd0, state0}, 64'd2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_state", {62'd0, state0}, 64'd0);
    chk("async_rst_fill", {59'd0, fill0}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read(0, 4'd0, 1'b0, 5'd0, 64'd0, 64'd0);

    for (int n = 0; n < 10 && (q0.size() != 0 || q1.size() != 0); n++) tick();
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
